// File: rtl/ehl_ahb_slv_arbiter.sv
// rtl/ehl_ahb_slv_arbiter.sv - per-slave-port AHB matrix arbiter with burst lock
//
// Purpose:
//   Shares one AHB slave port between MNUM masters. Address-phase ownership
//   (addr_gnt) and data-phase ownership (data_gnt) are tracked separately so
//   the matrix can steer the address/control mux and the read-data/response
//   return path independently. A granted burst is never broken: the owner
//   keeps the port while it issues BUSY or SEQ.
//
// Parameters:
//   MNUM        number of masters (1..16)
//   FIXED_PRIO  0: round-robin, 1: fixed priority (lowest index wins)
//
// Ports:
//   hclk         AHB clock
//   hresetn      synchronous active-low reset
//   req          per-master NONSEQ request to this slave (already decoded/route-permitted)
//   im_htrans    htrans of every master, master m at [2m+1:2m]
//   hready       hready of this slave port; low freezes all state
//   addr_gnt     one-hot address-phase owner (registered)
//   addr_gnt_id  binary index of addr_gnt, 0 when no owner
//   addr_valid   any address-phase owner present
//   data_gnt     one-hot data-phase owner (registered)
//   m_stall      requesting masters that do not own the address phase

module ehl_ahb_slv_arbiter #(
  parameter int MNUM       = 2,
  parameter int FIXED_PRIO = 0
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic [MNUM-1:0]   req,
  input  logic [2*MNUM-1:0] im_htrans,
  input  logic              hready,
  output logic [MNUM-1:0]   addr_gnt,
  output logic [3:0]        addr_gnt_id,
  output logic              addr_valid,
  output logic [MNUM-1:0]   data_gnt,
  output logic [MNUM-1:0]   m_stall
);

  logic [3:0]      rr_ptr;
  logic [3:0]      next_rr;
  logic [MNUM-1:0] next_addr_gnt;
  logic [MNUM-1:0] next_data_gnt;
  logic [1:0]      owner_htrans;
  logic            owner_continue;
  logic            found;
  int              win;
  int              idx;

  // Owner index and the htrans it is currently driving. addr_gnt is one-hot0,
  // so at most one iteration matches.
  always_comb begin
    addr_gnt_id  = '0;
    owner_htrans = '0;
    for (int i = 0; i < MNUM; i++) begin
      if (addr_gnt[i]) begin
        addr_gnt_id  = 4'(i);
        owner_htrans = im_htrans[2*i +: 2];
      end
    end
  end

  assign addr_valid = |addr_gnt;

  // BUSY (01) and SEQ (11) both have bit 0 set: the owner is mid-burst.
  assign owner_continue = addr_valid & owner_htrans[0];

  assign m_stall = req & ~addr_gnt;

  // Winner selection among requesters.
  always_comb begin
    found = 1'b0;
    win   = 0;
    idx   = 0;
    if (FIXED_PRIO != 0) begin
      for (int i = MNUM - 1; i >= 0; i--) begin
        if (req[i]) begin
          found = 1'b1;
          win   = i;
        end
      end
    end else begin
      // Scan upward starting just after the last winner, wrapping at MNUM.
      for (int k = 1; k <= MNUM; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= MNUM) begin
          idx = idx - MNUM;
        end
        if (!found && req[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
    end
  end

  // Next grant state. No parking: with no owner-continue and no requester the
  // port goes ungranted, so the slave sees IDLE.
  always_comb begin
    next_addr_gnt = addr_gnt;
    next_rr       = rr_ptr;
    if (!owner_continue) begin
      next_addr_gnt = '0;
      if (found) begin
        next_addr_gnt[win] = 1'b1;
        next_rr            = 4'(win);
      end
    end
    // Only NONSEQ/SEQ (bit 1 set) open a data phase; BUSY and IDLE do not.
    next_data_gnt = owner_htrans[1] ? addr_gnt : '0;
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      addr_gnt <= '0;
      data_gnt <= '0;
      rr_ptr   <= 4'(MNUM - 1);
    end else if (hready) begin
      addr_gnt <= next_addr_gnt;
      data_gnt <= next_data_gnt;
      rr_ptr   <= next_rr;
    end
  end

endmodule

// File: tb/tb_ehl_ahb_slv_arbiter.sv
// tb/tb_ehl_ahb_slv_arbiter.sv - directed self-checking bench for ehl_ahb_slv_arbiter

module tb_ehl_ahb_slv_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic       hclk = 1'b0;
  logic       hresetn;
  logic [1:0] req;
  logic [1:0] ht0;
  logic [1:0] ht1;
  logic [3:0] im_htrans;
  logic       hready;

  logic [1:0] rr_addr_gnt, rr_data_gnt, rr_m_stall;
  logic [3:0] rr_addr_gnt_id;
  logic       rr_addr_valid;
  logic [1:0] fp_addr_gnt, fp_data_gnt, fp_m_stall;
  logic [3:0] fp_addr_gnt_id;
  logic       fp_addr_valid;

  int checks = 0;
  int errors = 0;

  assign im_htrans = {ht1, ht0};

  always #5 hclk = ~hclk;

  ehl_ahb_slv_arbiter #(.MNUM(2), .FIXED_PRIO(0)) u_rr (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .req         (req),
    .im_htrans   (im_htrans),
    .hready      (hready),
    .addr_gnt    (rr_addr_gnt),
    .addr_gnt_id (rr_addr_gnt_id),
    .addr_valid  (rr_addr_valid),
    .data_gnt    (rr_data_gnt),
    .m_stall     (rr_m_stall)
  );

  ehl_ahb_slv_arbiter #(.MNUM(2), .FIXED_PRIO(1)) u_fp (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .req         (req),
    .im_htrans   (im_htrans),
    .hready      (hready),
    .addr_gnt    (fp_addr_gnt),
    .addr_gnt_id (fp_addr_gnt_id),
    .addr_valid  (fp_addr_valid),
    .data_gnt    (fp_data_gnt),
    .m_stall     (fp_m_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk_rr(input string tag, input logic [1:0] ag, input logic [1:0] dg);
    chk({tag, "_addr_gnt"}, 32'(rr_addr_gnt), 32'(ag));
    chk({tag, "_data_gnt"}, 32'(rr_data_gnt), 32'(dg));
  endtask

  initial begin
    hresetn = 1'b0;
    req     = 2'b00;
    ht0     = IDLE;
    ht1     = IDLE;
    hready  = 1'b1;
    tick();
    tick();
    chk("rst_addr_gnt", 32'(rr_addr_gnt), 0);
    chk("rst_data_gnt", 32'(rr_data_gnt), 0);
    chk("rst_addr_valid", 32'(rr_addr_valid), 0);
    chk("rst_addr_gnt_id", 32'(rr_addr_gnt_id), 0);
    hresetn = 1'b1;

    // 1: single NONSEQ from M0
    req = 2'b01; ht0 = NONSEQ;
    #1;
    chk("t1_stall_before", 32'(rr_m_stall), 32'h1);
    tick();
    chk_rr("t1_e1", 2'b01, 2'b00);
    chk("t1_id", 32'(rr_addr_gnt_id), 0);
    chk("t1_valid", 32'(rr_addr_valid), 1);
    chk("t1_stall_granted", 32'(rr_m_stall), 0);
    tick();
    chk_rr("t1_e2", 2'b01, 2'b01);
    req = 2'b00; ht0 = IDLE;
    tick();
    chk_rr("t1_e3", 2'b00, 2'b00);

    // 2: two masters, repeated singles, fresh reset -> alternate starting with M0
    hresetn = 1'b0;
    tick();
    hresetn = 1'b1;
    req = 2'b11; ht0 = NONSEQ; ht1 = NONSEQ;
    #1;
    chk("t2_stall_both", 32'(rr_m_stall), 32'h3);
    tick();
    chk_rr("t2_e1", 2'b01, 2'b00);
    chk("t2_stall_m1", 32'(rr_m_stall), 32'h2);
    tick();
    chk_rr("t2_e2", 2'b10, 2'b01);
    chk("t2_id_m1", 32'(rr_addr_gnt_id), 1);
    chk("t2_stall_m0", 32'(rr_m_stall), 32'h1);
    tick();
    chk_rr("t2_e3", 2'b01, 2'b10);
    tick();
    chk_rr("t2_e4", 2'b10, 2'b01);

    // 5: hready low for 3 cycles freezes grants and pointer
    hready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_rr("t5_hold", 2'b10, 2'b01);
      chk("t5_stall", 32'(rr_m_stall), 32'h1);
    end
    hready = 1'b1;
    tick();
    chk_rr("t5_resume", 2'b01, 2'b10);

    // cleanup: everyone idle
    req = 2'b00; ht0 = IDLE; ht1 = IDLE;
    tick();
    chk_rr("t3_idle", 2'b00, 2'b00);

    // 3: M1 INCR4, M0 starts requesting while M1 is on its first SEQ
    req = 2'b10; ht1 = NONSEQ;
    tick();
    chk_rr("t3_e1", 2'b10, 2'b00);
    tick();
    chk_rr("t3_e2", 2'b10, 2'b10);
    req = 2'b01; ht0 = NONSEQ; ht1 = SEQ;
    #1;
    chk("t3_stall_m0", 32'(rr_m_stall), 32'h1);
    tick();
    chk_rr("t3_e3", 2'b10, 2'b10);
    tick();
    chk_rr("t3_e4", 2'b10, 2'b10);
    tick();
    chk_rr("t3_e5", 2'b10, 2'b10);
    ht1 = IDLE;
    tick();
    chk_rr("t3_e6", 2'b01, 2'b00);
    tick();
    chk_rr("t3_e7", 2'b01, 2'b01);
    req = 2'b00; ht0 = IDLE;
    tick();
    chk_rr("t3_e8", 2'b00, 2'b00);

    // 4: M1 burst with BUSY, M0 requesting
    req = 2'b10; ht1 = NONSEQ;
    tick();
    chk_rr("t4_e1", 2'b10, 2'b00);
    tick();
    chk_rr("t4_e2", 2'b10, 2'b10);
    req = 2'b01; ht0 = NONSEQ; ht1 = SEQ;
    tick();
    chk_rr("t4_e3", 2'b10, 2'b10);
    ht1 = BUSY;
    tick();
    chk_rr("t4_busy", 2'b10, 2'b00);
    ht1 = SEQ;
    tick();
    chk_rr("t4_e5", 2'b10, 2'b10);
    ht1 = IDLE;
    tick();
    chk_rr("t4_e6", 2'b01, 2'b00);
    req = 2'b00; ht0 = IDLE;
    tick();
    chk_rr("t4_e7", 2'b00, 2'b00);

    // 6a: reset in the middle of an M1 burst on both instances
    req = 2'b10; ht1 = NONSEQ;
    tick();
    tick();
    req = 2'b00; ht1 = SEQ;
    tick();
    chk_rr("t6_burst", 2'b10, 2'b10);
    chk("t6_fp_burst", 32'(fp_addr_gnt), 32'h2);
    hresetn = 1'b0;
    tick();
    chk_rr("t6_rst", 2'b00, 2'b00);
    chk("t6_rst_id", 32'(rr_addr_gnt_id), 0);
    chk("t6_rst_valid", 32'(rr_addr_valid), 0);
    chk("t6_fp_rst_gnt", 32'(fp_addr_gnt), 0);
    chk("t6_fp_rst_data", 32'(fp_data_gnt), 0);
    hresetn = 1'b1;
    ht1 = IDLE;

    // 6b: continuous singles from both; fixed priority keeps M0, RR alternates from M0
    req = 2'b11; ht0 = NONSEQ; ht1 = NONSEQ;
    tick();
    chk("t6_rr_first", 32'(rr_addr_gnt), 32'h1);
    for (int c = 0; c < 4; c++) begin
      chk("t6_fp_gnt", 32'(fp_addr_gnt), 32'h1);
      chk("t6_fp_stall", 32'(fp_m_stall), 32'h2);
      tick();
    end
    chk("t6_fp_data", 32'(fp_data_gnt), 32'h1);
    req = 2'b00; ht0 = IDLE; ht1 = IDLE;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
